// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, interrupts and mret,
// sequences the CSR writes one per cycle, then redirects fetch and flushes.
module trap_ctrl #(
   parameter int XLEN        = 32,
   parameter int NUM_EXT_IRQ = 4,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_EXT_IRQ-1:0] ext_irq_i,
   input  logic                   soft_irq_i,
   input  logic                   timer_irq_i,
   input  logic                   ecall_i,
   input  logic                   ebreak_i,
   input  logic                   mret_i,
   input  logic                   illegal_i,
   input  logic [XLEN-1:0]        pc_i,
   input  logic [31:0]            inst_i,
   input  logic                   pipe_busy_i,
   input  logic [XLEN-1:0]        csr_mtvec_i,
   input  logic [XLEN-1:0]        csr_mepc_i,
   input  logic [XLEN-1:0]        csr_mstatus_i,
   input  logic [XLEN-1:0]        csr_mie_i,
   output logic                   csr_we_o,
   output logic [11:0]            csr_waddr_o,
   output logic [XLEN-1:0]        csr_wdata_o,
   output logic [XLEN-1:0]        mip_o,
   output logic                   stallreq_o,
   output logic                   flush_o,
   output logic                   jump_req_o,
   output logic [XLEN-1:0]        jump_pc_o,
   output logic [3:0]             irq_id_o
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MTVAL   = 12'h343;

   typedef enum logic [2:0] {
      IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, R_MSTATUS, JUMP
   } state_t;

   state_t          state;
   logic [XLEN-1:0] cause_q, epc_q, tval_q, ms_q, tgt_q;
   logic [3:0]      irq_q;
   logic            mei_q;

   logic            meip, en_mei, en_msi, en_mti, any_trap;
   logic            take_trap, take_mret, intr, is_mei;
   logic [3:0]      code, ext_idx;
   logic [XLEN-1:0] tval, cause_next, base, target;
   logic            unused;

   // mstatus on trap entry: MPIE<=MIE, MIE<=0, MPP<=M
   function automatic logic [XLEN-1:0] trap_ms(input logic [XLEN-1:0] s);
      trap_ms        = s;
      trap_ms[7]     = s[3];
      trap_ms[3]     = 1'b0;
      trap_ms[12:11] = 2'b11;
   endfunction

   // mstatus on mret: MIE<=MPIE, MPIE<=1, MPP<=M
   function automatic logic [XLEN-1:0] mret_ms(input logic [XLEN-1:0] s);
      mret_ms        = s;
      mret_ms[3]     = s[7];
      mret_ms[7]     = 1'b1;
      mret_ms[12:11] = 2'b11;
   endfunction

   // only MSIE/MTIE/MEIE of mie are meaningful here
   assign unused = ^csr_mie_i;

   // live pending bits and globally enabled interrupts
   always_comb begin
      meip     = |ext_irq_i;
      en_mei   = meip & csr_mie_i[11] & csr_mstatus_i[3];
      en_msi   = soft_irq_i & csr_mie_i[3] & csr_mstatus_i[3];
      en_mti   = timer_irq_i & csr_mie_i[7] & csr_mstatus_i[3];
      mip_o     = '0;
      mip_o[3]  = soft_irq_i;
      mip_o[7]  = timer_irq_i;
      mip_o[11] = meip;
   end

   // lowest-numbered active external line wins
   always_comb begin
      ext_idx = '0;
      for (int i = NUM_EXT_IRQ - 1; i >= 0; i--)
         if (ext_irq_i[i]) ext_idx = 4'(i);
   end

   // event arbitration, cause/tval selection and redirect target
   always_comb begin
      any_trap  = illegal_i | ebreak_i | ecall_i | en_mei | en_msi | en_mti;
      take_trap = (state == IDLE) & ~pipe_busy_i & any_trap;
      take_mret = (state == IDLE) & ~pipe_busy_i & mret_i & ~any_trap;
      intr      = 1'b0;
      is_mei    = 1'b0;
      code      = 4'd0;
      tval      = '0;
      if (illegal_i) begin
         code = 4'd2;
         tval = XLEN'(inst_i);
      end else if (ebreak_i) begin
         code = 4'd3;
         tval = pc_i;
      end else if (ecall_i) begin
         code = 4'd11;
      end else if (en_mei) begin
         code   = 4'd11;
         intr   = 1'b1;
         is_mei = 1'b1;
      end else if (en_msi) begin
         code = 4'd3;
         intr = 1'b1;
      end else if (en_mti) begin
         code = 4'd7;
         intr = 1'b1;
      end
      cause_next            = '0;
      cause_next[XLEN-1]    = intr;
      cause_next[3:0]       = code;
      base                  = {csr_mtvec_i[XLEN-1:2], 2'b00};
      if (intr && VECTORED_EN && csr_mtvec_i[1:0] == 2'b01)
         target = base + XLEN'({code, 2'b00});
      else
         target = base;
   end

   assign stallreq_o = take_trap | take_mret | (state != IDLE);

   // sequencer with registered CSR-write and redirect outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cause_q     <= '0;
         epc_q       <= '0;
         tval_q      <= '0;
         ms_q        <= '0;
         tgt_q       <= '0;
         irq_q       <= '0;
         mei_q       <= 1'b0;
         csr_we_o    <= 1'b0;
         csr_waddr_o <= '0;
         csr_wdata_o <= '0;
         jump_req_o  <= 1'b0;
         flush_o     <= 1'b0;
         jump_pc_o   <= '0;
         irq_id_o    <= '0;
      end else begin
         csr_we_o    <= 1'b0;
         csr_waddr_o <= '0;
         csr_wdata_o <= '0;
         jump_req_o  <= 1'b0;
         flush_o     <= 1'b0;
         jump_pc_o   <= '0;
         irq_id_o    <= '0;
         case (state)
            IDLE: begin
               if (take_trap) begin
                  cause_q     <= cause_next;
                  epc_q       <= pc_i;
                  tval_q      <= tval;
                  ms_q        <= csr_mstatus_i;
                  tgt_q       <= target;
                  irq_q       <= ext_idx;
                  mei_q       <= is_mei;
                  state       <= W_MEPC;
                  csr_we_o    <= 1'b1;
                  csr_waddr_o <= A_MEPC;
                  csr_wdata_o <= pc_i;
               end else if (take_mret) begin
                  ms_q        <= csr_mstatus_i;
                  tgt_q       <= csr_mepc_i;
                  mei_q       <= 1'b0;
                  state       <= R_MSTATUS;
                  csr_we_o    <= 1'b1;
                  csr_waddr_o <= A_MSTATUS;
                  csr_wdata_o <= mret_ms(csr_mstatus_i);
               end
            end
            W_MEPC: begin
               state       <= W_MCAUSE;
               csr_we_o    <= 1'b1;
               csr_waddr_o <= A_MCAUSE;
               csr_wdata_o <= cause_q;
            end
            W_MCAUSE: begin
               state       <= W_MTVAL;
               csr_we_o    <= 1'b1;
               csr_waddr_o <= A_MTVAL;
               csr_wdata_o <= tval_q;
            end
            W_MTVAL: begin
               state       <= W_MSTATUS;
               csr_we_o    <= 1'b1;
               csr_waddr_o <= A_MSTATUS;
               csr_wdata_o <= trap_ms(ms_q);
            end
            W_MSTATUS, R_MSTATUS: begin
               state      <= JUMP;
               jump_req_o <= 1'b1;
               flush_o    <= 1'b1;
               jump_pc_o  <= tgt_q;
               irq_id_o   <= mei_q ? irq_q : 4'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
